// File: rtl/issue_scoreboard.sv
// In-order single-issue dispatch with a 32-entry register busy scoreboard.
// Holds one decoded op and issues it to ALU, BU or DU once hazards clear.
module issue_scoreboard #(
    parameter logic [2:0] CLS_ALU = 3'd1,
    parameter logic [2:0] CLS_BU  = 3'd2,
    parameter logic [2:0] CLS_DUL = 3'd3,
    parameter logic [2:0] CLS_DUS = 3'd4,
    parameter int         STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [8:0]         dec_op,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic [4:0]         dec_rd,
    input  logic               dec_regw,
    input  logic [31:0]        dec_imm,
    input  logic [31:0]        dec_pc,
    input  logic               flush,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    output logic               alu_valid,
    output logic               bu_valid,
    output logic               du_valid,
    input  logic               alu_ready,
    input  logic               bu_ready,
    input  logic               du_ready,
    output logic [8:0]         iss_op,
    output logic [4:0]         iss_rs1,
    output logic [4:0]         iss_rs2,
    output logic [4:0]         iss_rd,
    output logic               iss_regw,
    output logic [31:0]        iss_imm,
    output logic [31:0]        iss_pc,
    output logic               ill_op,
    output logic [STALL_W-1:0] stall_cnt
);

    logic        hold_v;
    logic [31:0] busy;
    logic [31:0] wb_mask;
    logic [31:0] set_mask;
    logic [31:0] ebusy;
    logic        hazard;
    logic        go;
    logic        fire;
    logic        tgt_ready;
    logic        accept;
    logic        dec_legal;
    logic [2:0]  iss_cls;
    logic [2:0]  dec_cls;

    assign iss_cls = iss_op[8:6];
    assign dec_cls = dec_op[8:6];

    // A writeback in this cycle is already seen as not busy.
    assign wb_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign ebusy   = busy & ~wb_mask;

    assign hazard = ebusy[iss_rs1] | ebusy[iss_rs2]
                  | (iss_regw & ebusy[iss_rd]);
    assign go     = hold_v & ~flush & ~hazard;

    always_comb begin
        alu_valid = 1'b0;
        bu_valid  = 1'b0;
        du_valid  = 1'b0;
        tgt_ready = 1'b0;
        unique case (1'b1)
            (iss_cls == CLS_ALU): begin
                alu_valid = go;
                tgt_ready = alu_ready;
            end
            (iss_cls == CLS_BU): begin
                bu_valid  = go;
                tgt_ready = bu_ready;
            end
            (iss_cls == CLS_DUL),
            (iss_cls == CLS_DUS): begin
                du_valid  = go;
                tgt_ready = du_ready;
            end
            default: ;
        endcase
    end

    assign fire      = go & tgt_ready;
    assign dec_ready = ~flush & (~hold_v | fire);
    assign accept    = dec_valid & dec_ready;
    assign dec_legal = (dec_cls == CLS_ALU) | (dec_cls == CLS_BU)
                     | (dec_cls == CLS_DUL) | (dec_cls == CLS_DUS);

    assign set_mask = (fire && iss_regw && iss_rd != 5'd0)
                    ? (32'd1 << iss_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            busy <= (ebusy | set_mask) & 32'hFFFF_FFFE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v   <= 1'b0;
            iss_op   <= 9'd0;
            iss_rs1  <= 5'd0;
            iss_rs2  <= 5'd0;
            iss_rd   <= 5'd0;
            iss_regw <= 1'b0;
            iss_imm  <= 32'd0;
            iss_pc   <= 32'd0;
        end else if (flush) begin
            hold_v <= 1'b0;
        end else if (accept && dec_legal) begin
            hold_v   <= 1'b1;
            iss_op   <= dec_op;
            iss_rs1  <= dec_rs1;
            iss_rs2  <= dec_rs2;
            iss_rd   <= dec_rd;
            iss_regw <= dec_regw;
            iss_imm  <= dec_imm;
            iss_pc   <= dec_pc;
        end else if (fire) begin
            hold_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ill_op    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            ill_op <= accept & ~dec_legal;
            if (hold_v && !fire && !flush && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order single-issue dispatch controller between the instruction decoder and the functional units (ALU, branch unit BU, data unit DU).
- Holds one decoded instruction and tracks pending register writes in a 32-entry busy scoreboard.
- Issues the instruction to the unit selected by its op class once RAW/WAW hazards clear and the unit is ready.
- Clears busy bits on writeback broadcasts and drops the held instruction on branch flush.

Parameters:
- CLS_ALU, 3'd1, op class code (alu_op[8:6]) routed to the ALU port.
- CLS_BU, 3'd2, class code routed to the BU port.
- CLS_DUL, 3'd3, load class code routed to the DU port.
- CLS_DUS, 3'd4, store class code routed to the DU port.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoder presents an instruction (decoder's Instvalid).
- dec_ready  out  1  controller accepts this cycle.
- dec_op  in  9  decoded op; [8:6] class, [5:0] sub-op.
- dec_rs1, dec_rs2, dec_rd  in  5 each  source/destination register numbers.
- dec_regw  in  1  instruction writes dec_rd.
- dec_imm  in  32  extended immediate.
- dec_pc  in  32  instruction PC.
- flush  in  1  branch mispredict/redirect; kill held instruction.
- wb_valid  in  1  writeback broadcast valid.
- wb_rd  in  5  register being written back.
- alu_valid / bu_valid / du_valid  out  1 each  issue strobe per unit.
- alu_ready / bu_ready / du_ready  in  1 each  unit can accept.
- iss_op  out  9  held op.
- iss_rs1, iss_rs2, iss_rd  out  5 each  held register fields.
- iss_regw  out  1  held write flag.
- iss_imm, iss_pc  out  32 each  held immediate/PC.
- ill_op  out  1  registered one-cycle pulse: illegal class was rejected.
- stall_cnt  out  STALL_W  saturating count of cycles held-but-not-issued.

Behaviour:
- Reset: hold_v=0, busy[31:0]=0, ill_op=0, stall_cnt=0. All *_valid are 0 because they are qualified by hold_v. Payload registers are cleared to 0.
- Accept:
  - dec_ready = !flush && (!hold_v || fire). This is combinational and includes the unit ready inputs.
  - Accept = dec_valid && dec_ready. A legal class loads the hold register next edge, so earliest issue is one cycle after accept.
  - A class not in {ALU,BU,DUL,DUS} is consumed (dec_ready honoured) but not loaded; ill_op=1 for the next cycle only.
- Hazards:
  - Effective busy: ebusy = busy & ~(wb_valid ? onehot(wb_rd) : 0). A same-cycle writeback is visible as not busy.
  - r0 is never busy; set attempts to r0 are ignored.
- Issue condition, with tgt = the unit port selected by iss_op[8:6]. fire = hold_v && !flush && !ebusy[iss_rs1] && !ebusy[iss_rs2] && !(iss_regw && ebusy[iss_rd]) && tgt_ready.
  - tgt_valid = hold_v && !flush && no hazard. This does not depend on tgt_ready (valid must not wait on ready).
  - Non-target valids are 0.
  - DUL and DUS both use the du port.
- Scoreboard update per edge:
  - busy_next = ebusy | (fire && iss_regw && iss_rd!=0 ? onehot(iss_rd) : 0).
  - When set and clear hit the same register in the same cycle, set wins.
  - A writeback to a non-busy register is harmless (bit stays 0).
- Hold register:
  - On fire without accept: hold_v goes to 0.
  - On fire with accept: the new instruction loads back-to-back, giving one issue per cycle sustained.
- Flush:
  - Takes effect in the same cycle: no issue, no accept, hold_v=0 next edge.
  - Busy bits are kept, because in-flight ops still write back.
  - Flush with a simultaneous writeback still clears that busy bit.
- stall_cnt: increments each cycle with hold_v && !fire && !flush and saturates at all-ones. Reset only by rst.
- Reset mid-operation: everything returns to reset values on the next edge regardless of other inputs.

Test Plan:
- Reset, then ALU op "add" r3<-r1,r2, regw=1, alu_ready=1 -> accepted cycle 0; alu_valid=1, iss_rd=3 at cycle 1; busy[3]=1 at cycle 2.
- Back-to-back: r3<-r1,r2 then r4<-r3,r5 with no writeback -> second op holds, alu_valid=0 and stall_cnt increments each cycle. Assert wb_valid with wb_rd=3 -> second op issues in that same cycle.
- WAW plus same-cycle set/clear: busy[7]=1, held op writes r7, wb_rd=7 that cycle -> op issues and busy[7] stays 1. A write to r0 never sets busy[0].
- Unit routing/backpressure: held DUS op with du_ready=0 for 3 cycles -> du_valid=1 steady, dec_ready=0, stall_cnt=3. Then du_ready=1 -> fire, and a pending decoder op is accepted in the same cycle.
- Flush: held BU op with flush=1 -> bu_valid=0 and dec_ready=0 that cycle; hold_v=0 next cycle; pre-existing busy bits unchanged.
- Illegal class: dec_op[8:6]=3'd7 -> dec_ready=1, no unit valid ever asserted, ill_op=1 for exactly one cycle. Assert rst mid-stall -> all outputs return to 0 next edge.
